// File: rtl/sipo_shift_register_rx.sv
// ---------------------------------------------------------------------------
// sipo_shift_register_rx
//
// Serial-in / parallel-out deserializer for the receive end of the PISO link.
// One bit is captured per enabled clock. Bits are assembled into WIDTH-bit
// words, and each completed word is presented on a holding register. The
// holding register uses a valid/ready handshake and has a sticky overrun flag.
//
// Parameters
//   WIDTH      word length in bits (>= 2)
//   MSB_FIRST  1: first received bit lands in bit WIDTH-1, 0: in bit 0
//
// Ports
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   enable         bit strobe; serial_in is sampled only when high
//   frame_start    current enabled bit is bit 0 of a new word
//   serial_in      serial data
//   out_ready      consumer accepts parallel_out while out_valid is high
//   clear_overrun  synchronous clear of the overrun flag
//   shift_reg      live assembly register
//   bit_count      bits captured so far in the current word
//   parallel_out   last completed word
//   out_valid      parallel_out holds an unconsumed word
//   overrun        sticky: a word completed while the previous was unconsumed
// ---------------------------------------------------------------------------
module sipo_shift_register_rx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic                       frame_start,
    input  logic                       serial_in,
    input  logic                       out_ready,
    input  logic                       clear_overrun,
    output logic [WIDTH-1:0]           shift_reg,
    output logic [$clog2(WIDTH+1)-1:0] bit_count,
    output logic [WIDTH-1:0]           parallel_out,
    output logic                       out_valid,
    output logic                       overrun
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RECV = 1'b1
    } state_t;

    state_t                 r_state;
    logic [WIDTH-1:0]       r_shift;
    logic [CNT_W-1:0]       r_count;
    logic [WIDTH-1:0]       r_parallel;
    logic                   r_valid;
    logic                   r_overrun;

    // w_shifted: r_shift with serial_in appended.
    // w_first: a fresh word that holds serial_in as its only bit.
    logic [WIDTH-1:0]       w_shifted;
    logic [WIDTH-1:0]       w_first;

    generate
        if (MSB_FIRST) begin : g_msb
            assign w_shifted = {r_shift[WIDTH-2:0], serial_in};
            assign w_first   = {{(WIDTH-1){1'b0}}, serial_in};
        end else begin : g_lsb
            assign w_shifted = {serial_in, r_shift[WIDTH-1:1]};
            assign w_first   = {serial_in, {(WIDTH-1){1'b0}}};
        end
    endgenerate

    // Receive FSM, holding register, handshake and overrun flag.
    // The completion branch is written after the handshake clear. On an edge
    // where a word completes and out_ready is also high, the new word
    // therefore keeps out_valid high. The overrun set is written after
    // clear_overrun, so a set on the same edge as a clear wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_shift    <= {WIDTH{1'b0}};
            r_count    <= {CNT_W{1'b0}};
            r_parallel <= {WIDTH{1'b0}};
            r_valid    <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (clear_overrun) begin
                r_overrun <= 1'b0;
            end
            if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (enable && frame_start) begin
                        r_shift <= w_first;
                        r_count <= ONE_CNT;
                        r_state <= S_RECV;
                    end
                end
                S_RECV: begin
                    if (enable) begin
                        if (frame_start) begin
                            // Restart: discard the partial word.
                            r_shift <= w_first;
                            r_count <= ONE_CNT;
                        end else if (r_count == LAST_CNT) begin
                            r_parallel <= w_shifted;
                            r_valid    <= 1'b1;
                            if (r_valid && !out_ready) begin
                                r_overrun <= 1'b1;
                            end
                            r_shift <= {WIDTH{1'b0}};
                            r_count <= {CNT_W{1'b0}};
                            r_state <= S_IDLE;
                        end else begin
                            r_shift <= w_shifted;
                            r_count <= r_count + ONE_CNT;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_shift <= {WIDTH{1'b0}};
                    r_count <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign shift_reg    = r_shift;
    assign bit_count    = r_count;
    assign parallel_out = r_parallel;
    assign out_valid    = r_valid;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_sipo_shift_register_rx.sv
module tb_sipo_shift_register_rx;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       frame_start = 1'b0;
    logic       serial_in = 1'b0;
    logic       out_ready = 1'b0;
    logic       clear_overrun = 1'b0;

    logic [W-1:0] m_shift_reg, l_shift_reg;
    logic [3:0]   m_bit_count, l_bit_count;
    logic [W-1:0] m_parallel_out, l_parallel_out;
    logic         m_out_valid, l_out_valid;
    logic         m_overrun, l_overrun;

    int vectors = 0;
    int miscompares = 0;

    // Two instances share all stimulus: MSB-first and LSB-first.
    sipo_shift_register_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset_n(reset_n), .enable(enable), .frame_start(frame_start),
        .serial_in(serial_in), .out_ready(out_ready), .clear_overrun(clear_overrun),
        .shift_reg(m_shift_reg), .bit_count(m_bit_count), .parallel_out(m_parallel_out),
        .out_valid(m_out_valid), .overrun(m_overrun));

    sipo_shift_register_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset_n(reset_n), .enable(enable), .frame_start(frame_start),
        .serial_in(serial_in), .out_ready(out_ready), .clear_overrun(clear_overrun),
        .shift_reg(l_shift_reg), .bit_count(l_bit_count), .parallel_out(l_parallel_out),
        .out_valid(l_out_valid), .overrun(l_overrun));

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // rx[i] is the i-th bit received in the current word, and rx_n is the
    // number of bits received so far. rx_n == 0 means no word is in progress.
    logic [W-1:0] rx;
    int           rx_n = 0;
    logic [W-1:0] exp_par_m = 8'h00, exp_par_l = 8'h00;
    logic         exp_valid = 1'b0, exp_ovr = 1'b0;
    int           exp_completions = 0;
    int           seen_rises = 0;
    logic         prev_valid = 1'b0;

    // Returns the word built from n received bits, placed per bit order.
    function automatic logic [W-1:0] place(input logic [W-1:0] b, input int n, input bit msb);
        logic [W-1:0] v;
        v = 8'h00;
        for (int i = 0; i < n; i++) begin
            if (b[i]) begin
                if (msb) v = v | (8'h01 << (n - 1 - i));
                else     v = v | (8'h01 << (W - n + i));
            end
        end
        return v;
    endfunction

    task automatic model_reset();
        rx = 8'h00; rx_n = 0;
        exp_par_m = 8'h00; exp_par_l = 8'h00;
        exp_valid = 1'b0; exp_ovr = 1'b0;
    endtask

    always @(negedge reset_n) model_reset();

    always @(posedge clk) begin
        logic was_valid;
        if (!reset_n) begin
            model_reset();
        end else begin
            was_valid = exp_valid;
            if (clear_overrun) exp_ovr = 1'b0;
            if (exp_valid && out_ready) exp_valid = 1'b0;
            if (enable) begin
                if (frame_start) begin
                    rx = 8'h00; rx[0] = serial_in; rx_n = 1;
                end else if (rx_n > 0) begin
                    rx[rx_n] = serial_in;
                    rx_n = rx_n + 1;
                    if (rx_n == W) begin
                        exp_par_m = place(rx, W, 1'b1);
                        exp_par_l = place(rx, W, 1'b0);
                        if (was_valid && !out_ready) exp_ovr = 1'b1;
                        exp_valid = 1'b1;
                        rx = 8'h00; rx_n = 0;
                        exp_completions++;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Per-cycle comparison against the model, sampled 2 time units after each edge.
    always @(posedge clk) begin
        #2;
        check("shift_reg_msb", 32'(m_shift_reg), 32'(place(rx, rx_n, 1'b1)));
        check("shift_reg_lsb", 32'(l_shift_reg), 32'(place(rx, rx_n, 1'b0)));
        check("bit_count_msb", 32'(m_bit_count), 32'(rx_n));
        check("bit_count_lsb", 32'(l_bit_count), 32'(rx_n));
        check("parallel_msb",  32'(m_parallel_out), 32'(exp_par_m));
        check("parallel_lsb",  32'(l_parallel_out), 32'(exp_par_l));
        check("out_valid",     32'({m_out_valid, l_out_valid}), 32'({exp_valid, exp_valid}));
        check("overrun",       32'({m_overrun, l_overrun}), 32'({exp_ovr, exp_ovr}));
        if (m_out_valid && !prev_valid) seen_rises++;
        prev_valid = m_out_valid;
    end

    // ---------------- stimulus ----------------
    // One cycle: the inputs are set at the falling edge and held across the rising edge.
    task automatic drive(input logic en, input logic fs, input logic sin,
                         input logic rdy, input logic clr);
        enable = en; frame_start = fs; serial_in = sin;
        out_ready = rdy; clear_overrun = clr;
        @(negedge clk);
    endtask

    // Sends val in transmission order, most significant bit first. When gaps
    // is set, a disabled cycle follows each bit; that cycle has frame_start
    // high and serial_in inverted. out_ready and clear_overrun are applied
    // only on the last bit.
    task automatic send_word(input logic [W-1:0] val, input bit gaps,
                             input logic rdy_last, input logic clr_last);
        for (int i = 0; i < W; i++) begin
            drive(1'b1, (i == 0), val[W-1-i], (i == W-1) ? rdy_last : 1'b0,
                  (i == W-1) ? clr_last : 1'b0);
            if (gaps) drive(1'b0, 1'b1, ~val[W-1-i], 1'b0, 1'b0);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int c0, r0;
        @(negedge clk);
        check("reset_valid", 32'(m_out_valid), 32'd0);
        check("reset_par",   32'(m_parallel_out), 32'h00);
        @(negedge clk);
        reset_n = 1'b1;

        // Bits without frame_start while idle are ignored.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("idle_ignored", 32'(m_bit_count), 32'd0);

        // Basic MSB-first word 0x96.
        send_word(8'h96, 1'b0, 1'b0, 1'b0);
        check("model_pin_96", 32'(exp_par_m), 32'h96);
        check("basic_par_msb", 32'(m_parallel_out), 32'h96);
        check("basic_par_lsb", 32'(l_parallel_out), 32'h69);
        check("basic_valid", 32'(m_out_valid), 32'd1);
        check("basic_count", 32'(m_bit_count), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("handshake_valid", 32'(m_out_valid), 32'd0);

        // Enable gaps.
        send_word(8'h96, 1'b1, 1'b1, 1'b0);
        check("gap_par", 32'(m_parallel_out), 32'h96);
        check("gap_valid_ready_on_last", 32'(m_out_valid), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Overrun: two words with out_ready low.
        send_word(8'h96, 1'b0, 1'b0, 1'b0);
        send_word(8'h62, 1'b0, 1'b0, 1'b0);
        check("ovr_par", 32'(m_parallel_out), 32'h62);
        check("ovr_valid", 32'(m_out_valid), 32'd1);
        check("ovr_flag", 32'(m_overrun), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ovr_cleared", 32'(m_overrun), 32'd0);
        // Completion on the same edge as out_ready: no overrun.
        send_word(8'h5A, 1'b0, 1'b1, 1'b0);
        check("ready_coincide_ovr", 32'(m_overrun), 32'd0);
        check("ready_coincide_valid", 32'(m_out_valid), 32'd1);
        check("ready_coincide_par", 32'(m_parallel_out), 32'h5A);
        // Set and clear on the same edge: set wins.
        send_word(8'hC3, 1'b0, 1'b0, 1'b1);
        check("set_beats_clear", 32'(m_overrun), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Restart after 3 bits.
        c0 = exp_completions; r0 = seen_rises;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("restart_partial", 32'(m_bit_count), 32'd3);
        send_word(8'h00, 1'b0, 1'b0, 1'b0);
        check("restart_par", 32'(m_parallel_out), 32'h00);
        check("restart_model_once", 32'(exp_completions - c0), 32'd1);
        check("restart_dut_once", 32'(seen_rises - r0), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // LSB-first instance: bits 0,1,1,0,1,0,0,1 give 0x96.
        send_word(8'h69, 1'b0, 1'b0, 1'b0);
        check("lsb_first_par", 32'(l_parallel_out), 32'h96);
        check("model_pin_lsb", 32'(exp_par_l), 32'h96);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset mid-word at bit_count = 5.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("pre_reset_count", 32'(m_bit_count), 32'd5);
        reset_n = 1'b0;
        #1;
        check("async_reset_shift", 32'(m_shift_reg), 32'h00);
        check("async_reset_count", 32'(m_bit_count), 32'd0);
        check("async_reset_flags", 32'({m_out_valid, m_overrun}), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("post_reset_ignored", 32'(m_bit_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
